board_update_arbiter: RTL and testbench

BOARD_UPDATE_ARBITER -- requirements
Module: board_update_arbiter

---
 rtl/sudoku_pkg.sv | 18 +
 rtl/board_update_arbiter_if.sv | 26 ++
 rtl/rr_arbiter2.sv | 37 +++
 rtl/board_update_arbiter.sv | 173 +++++++++++++++++
 tb/tb_board_update_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared board geometry, cell index type, clear-sweep FSM states and an index range helper.
package sudoku_pkg;

  localparam int CELLS = 81;
  localparam int VAL_W = 4;

  typedef logic [6:0] idx_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic idx_in_range(input idx_t idx, input int cells);
    return (int'(idx) < cells);
  endfunction

endpackage

// File: rtl/board_update_arbiter_if.sv
// Write-request bus shared by the handwriting recogniser (port 0) and the solver (port 1).
interface board_update_arbiter_if #(
  parameter int VAL_W = sudoku_pkg::VAL_W
);
  import sudoku_pkg::*;

  logic             req0;
  logic             req1;
  idx_t             idx0;
  idx_t             idx1;
  logic [VAL_W-1:0] val0;
  logic [VAL_W-1:0] val1;
  logic             gnt0;
  logic             gnt1;

  modport master (
    output req0, req1, idx0, idx1, val0, val1,
    input  gnt0, gnt1
  );

  modport slave (
    input  req0, req1, idx0, idx1, val0, val1,
    output gnt0, gnt1
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; ptr_r holds the last winner (0 gives requester 1 priority).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       commit,
  output logic [1:0] gnt
);

  logic ptr_r;

  // Grant selection: on contention the requester that did not win last goes first.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (ptr_r == 1'b0) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end else begin
      gnt = req;
    end
  end

  // Last-winner pointer moves only when a grant actually commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (commit) begin
      ptr_r <= gnt[1];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/board_update_arbiter.sv
// Board write arbiter with clear sweep and frame-synchronised display refresh.
// Optional display shadow copy: define BOARD_ARB_SHADOW_EN.
module board_update_arbiter #(
  parameter int CELLS = sudoku_pkg::CELLS,
  parameter int VAL_W = sudoku_pkg::VAL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stage,
  input  logic                   vsync,
  input  logic                   clear,
  board_update_arbiter_if.slave  bus,
  output logic                   err,
  output logic                   busy,
  output logic [CELLS*VAL_W-1:0] board,
  output logic [CELLS-1:0]       board_blank,
  output logic                   frame_upd
);
  import sudoku_pkg::*;

  state_t                 state_r;
  idx_t                   cnt_r;
  logic                   busy_r;
  logic                   dirty_r;
  logic                   err_r;
  logic                   frame_upd_r;
  logic                   vs_hist_r;
  logic                   fall_r;
  logic [CELLS*VAL_W-1:0] board_r;
  logic [CELLS-1:0]       blank_r;

  logic [1:0]             elig_s;
  logic [1:0]             req_s;
  logic [1:0]             gnt_s;
  logic                   wr_vld_s;
  logic                   wr_ok_s;
  idx_t                   wr_idx_s;
  logic [VAL_W-1:0]       wr_val_s;
  logic                   frame_take_s;

  // Kept as a two-bit mask so a later stage encoding can open both requesters.
  assign elig_s   = {stage, ~stage};
  assign req_s    = {bus.req1, bus.req0} & elig_s & {2{~busy_r & ~clear}};
  assign wr_vld_s = |gnt_s;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_s),
    .commit (wr_vld_s),
    .gnt    (gnt_s)
  );

  assign bus.gnt0 = gnt_s[0];
  assign bus.gnt1 = gnt_s[1];

  // Route the winning requester's index and value to the write port.
  always_comb begin
    wr_idx_s = bus.idx0;
    wr_val_s = bus.val0;
    if (gnt_s[1]) begin
      wr_idx_s = bus.idx1;
      wr_val_s = bus.val1;
    end else begin
      wr_idx_s = bus.idx0;
      wr_val_s = bus.val0;
    end
  end

  assign wr_ok_s = wr_vld_s && idx_in_range(wr_idx_s, CELLS);

`ifdef BOARD_ARB_SHADOW_EN
  assign frame_take_s = fall_r && dirty_r && !busy_r;
`else
  assign frame_take_s = fall_r && dirty_r;
`endif

  // vsync falling-edge detector, registered so the boundary is a clean one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_hist_r <= 1'b1;
      fall_r    <= 1'b0;
    end else begin
      vs_hist_r <= vsync;
      fall_r    <= vs_hist_r & ~vsync;
    end
  end

  // Clear-sweep FSM together with the working board, dirty tracking and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 7'd0;
      busy_r      <= 1'b0;
      dirty_r     <= 1'b0;
      err_r       <= 1'b0;
      frame_upd_r <= 1'b0;
      board_r     <= {(CELLS*VAL_W){1'b0}};
      blank_r     <= {CELLS{1'b1}};
    end else begin
      err_r       <= wr_vld_s && !wr_ok_s;
      frame_upd_r <= frame_take_s;
      // A write landing on the refresh edge re-arms dirty, so it overrides the clear here.
      if (frame_take_s) begin
        dirty_r <= 1'b0;
      end else begin
        dirty_r <= dirty_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (clear) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
            cnt_r   <= 7'd0;
          end else if (wr_ok_s) begin
            board_r[int'(wr_idx_s)*VAL_W +: VAL_W] <= wr_val_s;
            blank_r[wr_idx_s] <= (wr_val_s == {VAL_W{1'b0}});
            dirty_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          board_r[int'(cnt_r)*VAL_W +: VAL_W] <= {VAL_W{1'b0}};
          blank_r[cnt_r] <= 1'b1;
          if (int'(cnt_r) == CELLS - 1) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 7'd0;
            dirty_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 7'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= 7'd0;
        end
      endcase
    end
  end

`ifdef BOARD_ARB_SHADOW_EN
  logic [CELLS*VAL_W-1:0] disp_board_r;
  logic [CELLS-1:0]       disp_blank_r;

  // Display copy is only reloaded on a frame boundary so the screen never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_board_r <= {(CELLS*VAL_W){1'b0}};
      disp_blank_r <= {CELLS{1'b1}};
    end else if (frame_take_s) begin
      disp_board_r <= board_r;
      disp_blank_r <= blank_r;
    end else begin
      disp_board_r <= disp_board_r;
      disp_blank_r <= disp_blank_r;
    end
  end

  assign board       = disp_board_r;
  assign board_blank = disp_blank_r;
`else
  assign board       = board_r;
  assign board_blank = blank_r;
`endif

  assign err       = err_r;
  assign busy      = busy_r;
  assign frame_upd = frame_upd_r;

endmodule

// File: tb/tb_board_update_arbiter.sv
// Directed self-checking bench for board_update_arbiter plus a standalone rr_arbiter2 alternation check.
module tb_board_update_arbiter;
  localparam int CELLS = 81;
  localparam int VAL_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic stage;
  logic vsync;
  logic clear;
  logic err;
  logic busy;
  logic frame_upd;
  logic [CELLS*VAL_W-1:0] board;
  logic [CELLS-1:0]       board_blank;

  logic [CELLS*VAL_W-1:0] exp_board;
  logic [CELLS-1:0]       exp_blank;

  logic [1:0] rr_req;
  logic [1:0] rr_gnt;
  logic       rr_commit;

  int checks   = 0;
  int failures = 0;
  int busy_cnt;
  int upd_cnt;
  int exp_upd;

  board_update_arbiter_if #(.VAL_W(VAL_W)) bus ();

  board_update_arbiter #(.CELLS(CELLS), .VAL_W(VAL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .stage       (stage),
    .vsync       (vsync),
    .clear       (clear),
    .bus         (bus),
    .err         (err),
    .busy        (busy),
    .board       (board),
    .board_blank (board_blank),
    .frame_upd   (frame_upd)
  );

  assign rr_commit = |rr_gnt;

  rr_arbiter2 u_rr_chk (
    .clk    (clk),
    .rst    (rst),
    .req    (rr_req),
    .commit (rr_commit),
    .gnt    (rr_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int idx, input logic [VAL_W-1:0] val);
    exp_board[idx*VAL_W +: VAL_W] = val;
    exp_blank[idx] = (val == 4'd0);
  endtask

  task automatic model_reset();
    exp_board = {(CELLS*VAL_W){1'b0}};
    exp_blank = {CELLS{1'b1}};
  endtask

  // One stage-0 write through port 0, with its grant checked before the edge.
  task automatic write0(input string tag, input int idx, input logic [VAL_W-1:0] val);
    stage = 1'b0;
    bus.req0 = 1'b1;
    bus.idx0 = 7'(idx);
    bus.val0 = val;
    #1;
    chk(tag, {511'd0, bus.gnt0}, 512'd1);
    tick();
    bus.req0 = 1'b0;
    if (idx < CELLS) model_write(idx, val);
  endtask

  initial begin
    rst = 1'b1; stage = 1'b0; vsync = 1'b1; clear = 1'b0; rr_req = 2'b00;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.idx0 = 7'd0; bus.idx1 = 7'd0; bus.val0 = 4'd0; bus.val1 = 4'd0;
    model_reset();
    #23;
    chk("rst_busy",  {511'd0, busy},      512'd0);
    chk("rst_err",   {511'd0, err},       512'd0);
    chk("rst_fupd",  {511'd0, frame_upd}, 512'd0);
    chk("rst_board", 512'(board),         512'd0);
    chk("rst_blank", 512'(board_blank),   512'(exp_blank));
    rst = 1'b0;
    tick();

    // Basic user write into cell 40.
    write0("w40_gnt0", 40, 4'd7);
    chk("w40_err", {511'd0, err}, 512'd0);
`ifdef BOARD_ARB_SHADOW_EN
    chk("w40_board_hidden", 512'(board[40*VAL_W +: VAL_W]), 512'd0);
`else
    chk("w40_board", 512'(board[40*VAL_W +: VAL_W]), 512'd7);
    chk("w40_blank", {511'd0, board_blank[40]}, 512'd0);
`endif
    vsync = 1'b0;
    tick();
    chk("f1_no_upd_yet", {511'd0, frame_upd}, 512'd0);
    tick();
    chk("f1_upd", {511'd0, frame_upd}, 512'd1);
    chk("f1_board40", 512'(board[40*VAL_W +: VAL_W]), 512'd7);
    chk("f1_blank40", {511'd0, board_blank[40]}, 512'd0);
    tick();
    chk("f1_upd_once", {511'd0, frame_upd}, 512'd0);
    vsync = 1'b1;

    // Stage 1: only the solver is eligible even with both requesting.
    stage = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.idx0 = 7'(20 + i); bus.val0 = 4'd9;
      bus.idx1 = 7'(10 + i); bus.val1 = 4'(i + 1);
      #1;
      chk($sformatf("s1_gnt0_%0d", i), {511'd0, bus.gnt0}, 512'd0);
      chk($sformatf("s1_gnt1_%0d", i), {511'd0, bus.gnt1}, 512'd1);
      tick();
      model_write(10 + i, 4'(i + 1));
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    stage = 1'b0;
    bus.req1 = 1'b1;
    #1;
    chk("s0_gnt1_masked", {511'd0, bus.gnt1}, 512'd0);
    bus.req1 = 1'b0;
`ifndef BOARD_ARB_SHADOW_EN
    chk("s1_board", 512'(board), 512'(exp_board));
    chk("s1_blank", 512'(board_blank), 512'(exp_blank));
`endif

    // Writing 0 makes a cell blank again.
    write0("blank_gnt", 40, 4'd0);
`ifndef BOARD_ARB_SHADOW_EN
    chk("blank40", {511'd0, board_blank[40]}, 512'd1);
`endif

    // Out-of-range indices: granted, no state change, err for one cycle.
    write0("oor81_gnt", 81, 4'd5);
    chk("oor81_err", {511'd0, err}, 512'd1);
    chk("oor81_fupd", {511'd0, frame_upd}, 512'd0);
    tick();
    chk("oor81_err_drop", {511'd0, err}, 512'd0);
    write0("oor127_gnt", 127, 4'd3);
    chk("oor127_err", {511'd0, err}, 512'd1);
`ifndef BOARD_ARB_SHADOW_EN
    chk("oor_board", 512'(board), 512'(exp_board));
    chk("oor_blank", 512'(board_blank), 512'(exp_blank));
`endif

    // Drain dirty, then a boundary with dirty=0 must not pulse.
    vsync = 1'b0; tick(); tick();
    chk("f2_upd", {511'd0, frame_upd}, 512'd1);
    chk("f2_board", 512'(board), 512'(exp_board));
    vsync = 1'b1; tick(); tick(); tick();
    vsync = 1'b0; tick(); tick();
    chk("f3_clean_no_upd", {511'd0, frame_upd}, 512'd0);
    vsync = 1'b1;

    // Clear sweep with a competing write; dirty is set beforehand.
    write0("pre_clr_gnt", 7, 4'd3);
    clear = 1'b1;
    bus.req0 = 1'b1; bus.idx0 = 7'd5; bus.val0 = 4'd9;
    #1;
    chk("clr_gnt0", {511'd0, bus.gnt0}, 512'd0);
    tick();
    clear = 1'b0;
    bus.req0 = 1'b1;
    #1;
    chk("clr_busy_gnt0", {511'd0, bus.gnt0}, 512'd0);
    bus.req0 = 1'b0;
    busy_cnt = 0; upd_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      busy_cnt++;
      if (c == 20) vsync = 1'b0;
      if (c == 24) vsync = 1'b1;
      if (c == 30) begin clear = 1'b1; end else begin clear = 1'b0; end
      if (frame_upd) upd_cnt++;
      tick();
    end
    clear = 1'b0;
    model_reset();
`ifdef BOARD_ARB_SHADOW_EN
    exp_upd = 0;
`else
    exp_upd = 1;
`endif
    chk("clr_busy_cycles", 512'(busy_cnt), 512'd81);
    chk("clr_fupd_during", 512'(upd_cnt), 512'(exp_upd));
`ifndef BOARD_ARB_SHADOW_EN
    chk("clr_blank", 512'(board_blank), 512'(exp_blank));
    chk("clr_board", 512'(board), 512'd0);
`endif

    // Reset in the middle of a sweep.
    write0("pre_rst_gnt", 12, 4'd6);
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (29) tick();
    chk("mid_sweep_busy", {511'd0, busy}, 512'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("mrst_busy",  {511'd0, busy},      512'd0);
    chk("mrst_err",   {511'd0, err},       512'd0);
    chk("mrst_fupd",  {511'd0, frame_upd}, 512'd0);
    chk("mrst_board", 512'(board),         512'd0);
    chk("mrst_blank", 512'(board_blank),   512'(exp_blank));
    tick();
    rst = 1'b0;
    tick();
    write0("post_rst_gnt", 3, 4'd2);
    chk("post_rst_busy", {511'd0, busy}, 512'd0);
`ifndef BOARD_ARB_SHADOW_EN
    chk("post_rst_cell3", 512'(board[3*VAL_W +: VAL_W]), 512'd2);
`endif

    // Round-robin alternation with both requesters open (pointer fresh from reset).
    rr_req = 2'b11;
    #1;
    chk("rr_0", 512'(rr_gnt), 512'd2);
    tick();
    chk("rr_1", 512'(rr_gnt), 512'd1);
    tick();
    chk("rr_2", 512'(rr_gnt), 512'd2);
    tick();
    chk("rr_3", 512'(rr_gnt), 512'd1);
    rr_req = 2'b01;
    tick();
    rr_req = 2'b11;
    #1;
    chk("rr_after_single0", 512'(rr_gnt), 512'd2);
    rr_req = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
